// File: rtl/fir_mac_ctrl.sv
// FIR tap sequencer and multiplier feeding an external accumulator (acc_module).
// Define FIR_MAC_OVERRUN_EN to get a sticky overrun flag for samples dropped while busy.
module fir_mac_ctrl #(
  parameter int unsigned TAPS   = 16,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned COEF_W = 12,
  parameter int unsigned ADDR_W = $clog2(TAPS)
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              probka_valid,
  input  logic [DATA_W-1:0] probka_in,
  output logic              probka_we,
  output logic [DATA_W-1:0] probka_wdata,
  output logic [ADDR_W-1:0] probka_addr,
  input  logic [DATA_W-1:0] probka_rdata,
  output logic [ADDR_W-1:0] coef_addr,
  input  logic [COEF_W-1:0] coef_rdata,
  output logic [20:0]       suma_wynik,
  output logic              FSM_reset_Acc,
  output logic              FSM_Acc_en,
  output logic              FSM_Acc_zapis,
  output logic              busy,
  output logic              done,
  output logic              overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StClr,
    StMac,
    StDrain,
    StSave,
    StDone
  } state_e;

  localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] TapsLo  = ADDR_W'(TAPS);
  localparam logic [ADDR_W-1:0] AddrOne = ADDR_W'(1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   k_q, k_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                rd_vld_q, rd_vld_d;
  logic                acc_vld_q, acc_vld_d;
  logic [20:0]         suma_q, suma_d;

  logic [ADDR_W-1:0]   rd_addr;
  logic [20:0]         samp_ext, coef_ext, prod;

  // (wr_ptr - k) mod TAPS; the true result is < TAPS, so modulo-2^ADDR_W arithmetic is exact.
  always_comb begin
    if (wr_ptr_q >= k_q) begin
      rd_addr = wr_ptr_q - k_q;
    end else begin
      rd_addr = wr_ptr_q + TapsLo - k_q;
    end
  end

  // The true product fits in 21 bits, so the low 21 bits of the extended product are exact.
  always_comb begin
    samp_ext = {{(21 - DATA_W){probka_rdata[DATA_W-1]}}, probka_rdata};
    coef_ext = {{(21 - COEF_W){coef_rdata[COEF_W-1]}}, coef_rdata};
    prod     = samp_ext * coef_ext;
  end

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    k_d           = k_q;
    sample_d      = sample_q;
    probka_we     = 1'b0;
    probka_wdata  = '0;
    probka_addr   = '0;
    coef_addr     = '0;
    FSM_reset_Acc = 1'b0;
    FSM_Acc_zapis = 1'b0;
    done          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (probka_valid) begin
          sample_d = probka_in;
          state_d  = StClr;
        end
      end
      StClr: begin
        FSM_reset_Acc = 1'b1;
        probka_we     = 1'b1;
        probka_addr   = wr_ptr_q;
        probka_wdata  = sample_q;
        k_d           = '0;
        state_d       = StMac;
      end
      StMac: begin
        probka_addr = rd_addr;
        coef_addr   = k_q;
        if (k_q == LastTap) begin
          k_d     = '0;
          state_d = StDrain;
        end else begin
          k_d = k_q + AddrOne;
        end
      end
      StDrain: begin
        if (k_q == AddrOne) begin
          k_d     = '0;
          state_d = StSave;
        end else begin
          k_d = k_q + AddrOne;
        end
      end
      StSave: begin
        FSM_Acc_zapis = 1'b1;
        wr_ptr_d      = (wr_ptr_q == LastTap) ? '0 : wr_ptr_q + AddrOne;
        state_d       = StDone;
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Read data lands one cycle after a MAC address; the product lands one cycle after that.
  always_comb begin
    rd_vld_d  = (state_q == StMac);
    acc_vld_d = rd_vld_q;
    suma_d    = rd_vld_q ? prod : suma_q;
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      state_q   <= StIdle;
      wr_ptr_q  <= '0;
      k_q       <= '0;
      sample_q  <= '0;
      rd_vld_q  <= 1'b0;
      acc_vld_q <= 1'b0;
      suma_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      k_q       <= k_d;
      sample_q  <= sample_d;
      rd_vld_q  <= rd_vld_d;
      acc_vld_q <= acc_vld_d;
      suma_q    <= suma_d;
    end
  end

  assign suma_wynik = suma_q;
  assign FSM_Acc_en = acc_vld_q;
  assign busy       = (state_q != StIdle);

`ifdef FIR_MAC_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q | (probka_valid & (state_q != StIdle));
  end

  always_ff @(posedge clk_b) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed bench for fir_mac_ctrl with TAPS=4, a delay-line RAM, coefficient ROM and accumulator.
module tb_fir_mac_ctrl;

  localparam int TAPS = 4;

  logic        clk_b = 1'b0;
  logic        rst;
  logic        tb_clr;
  logic        probka_valid;
  logic [7:0]  probka_in;
  logic        probka_we;
  logic [7:0]  probka_wdata;
  logic [1:0]  probka_addr;
  logic [7:0]  probka_rdata;
  logic [1:0]  coef_addr;
  logic [11:0] coef_rdata;
  logic [20:0] suma_wynik;
  logic        FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis;
  logic        busy, done, overrun;

  fir_mac_ctrl #(
    .TAPS  (TAPS),
    .DATA_W(8),
    .COEF_W(12)
  ) dut (
    .clk_b        (clk_b),
    .rst          (rst),
    .probka_valid (probka_valid),
    .probka_in    (probka_in),
    .probka_we    (probka_we),
    .probka_wdata (probka_wdata),
    .probka_addr  (probka_addr),
    .probka_rdata (probka_rdata),
    .coef_addr    (coef_addr),
    .coef_rdata   (coef_rdata),
    .suma_wynik   (suma_wynik),
    .FSM_reset_Acc(FSM_reset_Acc),
    .FSM_Acc_en   (FSM_Acc_en),
    .FSM_Acc_zapis(FSM_Acc_zapis),
    .busy         (busy),
    .done         (done),
    .overrun      (overrun)
  );

  always #5 clk_b = ~clk_b;

  // Delay-line RAM, coefficient ROM and accumulator, all with registered outputs.
  logic [7:0]  mem   [TAPS];
  logic [11:0] coefs [TAPS];
  logic [20:0] acc_q, wynik_q;

  always @(posedge clk_b) begin
    if (tb_clr) begin
      for (int i = 0; i < TAPS; i++) mem[i] <= 8'd0;
      acc_q   <= '0;
      wynik_q <= '0;
    end else begin
      if (probka_we) mem[probka_addr] <= probka_wdata;
      if (FSM_reset_Acc) acc_q <= '0;
      else if (FSM_Acc_en) acc_q <= acc_q + suma_wynik;
      if (FSM_Acc_zapis) wynik_q <= acc_q;
    end
    probka_rdata <= mem[probka_addr];
    coef_rdata   <= coefs[coef_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  int         c_rst, c_we, we_addr, en_first, en_last, en_cnt, c_zap, c_done, suma_first;
  int         overlap;
  logic [7:0] addr_pack, coef_pack;
  logic       post_rst_any;

  // One sample from cycle 0; optional stray valid at cycle 3 and reset at cycle 5.
  task automatic run(input int s, input bit inj_v, input bit inj_r);
    c_rst = -1; c_we = -1; we_addr = -1; en_first = -1; en_last = -1; en_cnt = 0;
    c_zap = -1; c_done = -1; suma_first = 0; overlap = 0;
    addr_pack = '0; coef_pack = '0; post_rst_any = 1'bx;
    @(posedge clk_b); #1;
    probka_valid = 1'b1;
    probka_in    = 8'(s);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk_b); #1;
      if (FSM_reset_Acc && c_rst < 0) c_rst = c;
      if (probka_we && c_we < 0) begin
        c_we    = c;
        we_addr = int'(probka_addr);
      end
      if (FSM_Acc_en) begin
        if (en_first < 0) begin
          en_first   = c;
          suma_first = int'($signed(suma_wynik));
        end
        en_last = c;
        en_cnt++;
      end
      if (int'(FSM_reset_Acc) + int'(FSM_Acc_en) + int'(FSM_Acc_zapis) > 1) overlap++;
      if (c >= 2 && c <= 5) begin
        addr_pack = {addr_pack[5:0], probka_addr};
        coef_pack = {coef_pack[5:0], coef_addr};
      end
      if (FSM_Acc_zapis && c_zap < 0) c_zap = c;
      if (done && c_done < 0) c_done = c;
      if (inj_r && c == 6) begin
        post_rst_any = busy | done | probka_we | FSM_reset_Acc | FSM_Acc_en | FSM_Acc_zapis |
                       overrun | (|suma_wynik) | (|probka_addr) | (|coef_addr) |
                       (|probka_wdata);
      end
      probka_valid = 1'b0;
      if (inj_v && c == 3) begin
        probka_valid = 1'b1;
        probka_in    = 8'sd50;
      end
      if (inj_r && c == 5) rst = 1'b1;
      if (inj_r && c == 6) rst = 1'b0;
      if (done && !inj_r) break;
      if (inj_r && c == 10) break;
    end
  endtask

`ifdef FIR_MAC_OVERRUN_EN
  localparam logic OverrunExp = 1'b1;
`else
  localparam logic OverrunExp = 1'b0;
`endif

  initial begin
    rst = 1'b1; tb_clr = 1'b1; probka_valid = 1'b0; probka_in = '0;
    coefs[0] = 12'd1; coefs[1] = 12'd2; coefs[2] = 12'd3; coefs[3] = 12'd4;
    repeat (3) @(posedge clk_b);
    #1;
    rst = 1'b0; tb_clr = 1'b0;

    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_overrun", overrun, 0);
    check("reset_suma", $signed(suma_wynik), 0);
    check("reset_strobes", {FSM_reset_Acc, FSM_Acc_en, FSM_Acc_zapis, probka_we}, 0);

    // Impulse response with coefficients 1,2,3,4, wr_ptr starting at 0.
    run(1, 0, 0);
    check("imp_reset_acc_cyc", c_rst, 1);
    check("imp_we_cyc", c_we, 1);
    check("imp_we_addr", we_addr, 0);
    check("imp_en_first", en_first, 4);
    check("imp_en_last", en_last, 7);
    check("imp_en_count", en_cnt, 4);
    check("imp_zapis_cyc", c_zap, 8);
    check("imp_done_cyc", c_done, 9);
    check("imp_strobe_overlap", overlap, 0);
    check("imp_addr_seq", addr_pack, 8'h39);
    check("imp_coef_seq", coef_pack, 8'h1B);
    check("imp_suma_first", suma_first, 1);
    check("imp_y0", $signed(wynik_q), 1);
    run(0, 0, 0);
    check("imp_y1", $signed(wynik_q), 2);
    run(0, 0, 0);
    check("imp_y2", $signed(wynik_q), 3);
    run(0, 0, 0);
    check("imp_y3", $signed(wynik_q), 4);
    check("imp_y3_done_cyc", c_done, 9);
    run(0, 0, 0);
    check("imp_y4", $signed(wynik_q), 0);

    // Extreme signs; wr_ptr is now 1 so the read walk wraps.
    coefs[0] = 12'd2047; coefs[1] = 12'd2047; coefs[2] = 12'd2047; coefs[3] = 12'd2047;
    run(-128, 0, 0);
    check("wrap_we_addr", we_addr, 1);
    check("wrap_addr_seq", addr_pack, 8'h4E);
    check("sign_suma", suma_first, -262016);
    check("sign_y0", $signed(wynik_q), -262016);
    run(-128, 0, 0);
    check("sign_y1", $signed(wynik_q), -524032);
    run(-128, 0, 0);
    check("sign_y2", $signed(wynik_q), -786048);
    run(-128, 0, 0);
    check("sign_y3", $signed(wynik_q), -1048064);

    // Stray valid while busy must be dropped.
    run(-128, 1, 0);
    check("ovr_done_cyc", c_done, 9);
    check("ovr_en_count", en_cnt, 4);
    check("ovr_result", $signed(wynik_q), -1048064);
    check("ovr_flag", overrun, OverrunExp);
    @(posedge clk_b); #1;
    check("ovr_idle_after", busy, 0);

    // Reset mid-run: abort without zapis/done, result register untouched.
    run(-128, 0, 1);
    check("rst_outputs_zero", post_rst_any, 0);
    check("rst_no_zapis", c_zap, -1);
    check("rst_no_done", c_done, -1);
    check("rst_result_kept", $signed(wynik_q), -1048064);
    check("rst_overrun_clr", overrun, 0);

    // wr_ptr restarts at 0; the delay line still holds -128 everywhere else.
    coefs[0] = 12'd1; coefs[1] = 12'd2; coefs[2] = 12'd3; coefs[3] = 12'd4;
    run(1, 0, 0);
    check("post_rst_we_addr", we_addr, 0);
    check("post_rst_done_cyc", c_done, 9);
    check("post_rst_result", $signed(wynik_q), -1151);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
